// File: rtl/fb_rect_writer_pkg.sv
// Shared frame-buffer geometry, FSM states and palette names for the
// rectangle writer and its clip stage.
package fb_pkg;

  localparam int FB_W   = 128;
  localparam int FB_H   = 64;
  localparam int ADDR_W = 13;
  localparam int COL_W  = 2;
  localparam int X_W    = 7;   // log2(FB_W)
  localparam int Y_W    = 6;   // log2(FB_H)

  // Exclusive clip limits, one bit wider than a coordinate.
  localparam logic [X_W:0] X_LIM = (X_W+1)'(FB_W);
  localparam logic [Y_W:0] Y_LIM = (Y_W+1)'(FB_H);

  localparam logic [COL_W-1:0] COL_BG = 2'd0;
  localparam logic [COL_W-1:0] COL_1  = 2'd1;
  localparam logic [COL_W-1:0] COL_2  = 2'd2;
  localparam logic [COL_W-1:0] COL_3  = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } state_t;

  // FB_W is a power of two, so row*FB_W + col is a plain concatenation.
  function automatic logic [ADDR_W-1:0] fb_addr(input logic [Y_W-1:0] row,
                                                input logic [X_W-1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/fb_rect_writer_if.sv
// Command handshake plus frame-buffer write port of the rectangle writer.
interface fb_rect_writer_if;
  import fb_pkg::*;

  logic                  I_cmd_valid;
  logic                  O_cmd_ready;
  logic                  I_cmd_clear;
  logic [X_W-1:0]        I_cmd_x;
  logic [Y_W-1:0]        I_cmd_y;
  logic [X_W:0]          I_cmd_w;
  logic [Y_W:0]          I_cmd_h;
  logic [COL_W-1:0]      I_cmd_col;
  logic                  I_stall;
  logic [ADDR_W-1:0]     O_address;
  logic                  O_ie;
  logic [COL_W-1:0]      O_colour;
  logic                  O_busy;
  logic                  O_done;

  modport master (
    output I_cmd_valid, I_cmd_clear, I_cmd_x, I_cmd_y, I_cmd_w, I_cmd_h,
           I_cmd_col, I_stall,
    input  O_cmd_ready, O_address, O_ie, O_colour, O_busy, O_done
  );

  modport slave (
    input  I_cmd_valid, I_cmd_clear, I_cmd_x, I_cmd_y, I_cmd_w, I_cmd_h,
           I_cmd_col, I_stall,
    output O_cmd_ready, O_address, O_ie, O_colour, O_busy, O_done
  );

endinterface

// File: rtl/fb_rect_writer_clip.sv
// Combinational clip of a fill rectangle to the screen; end coordinates are
// exclusive and one bit wider so x+w / y+h never wrap.
module fb_clip
  import fb_pkg::*;
(
  input  logic             clear,
  input  logic [X_W-1:0]   x,
  input  logic [Y_W-1:0]   y,
  input  logic [X_W:0]     w,
  input  logic [Y_W:0]     h,
  output logic [X_W-1:0]   x0,
  output logic [Y_W-1:0]   y0,
  output logic [X_W:0]     x_end,
  output logic [Y_W:0]     y_end,
  output logic             zero
);

  logic [X_W+1:0] x_sum;
  logic [Y_W+1:0] y_sum;

  // NOTE: every signal assigned in always_comb gets a default on entry, so no
  // path can leave it holding its old value and infer a latch.
  always_comb begin
    x_sum = {2'b00, x} + {1'b0, w};
    y_sum = {2'b00, y} + {1'b0, h};
    x0    = x;
    y0    = y;
    x_end = (x_sum > {1'b0, X_LIM}) ? X_LIM : x_sum[X_W:0];
    y_end = (y_sum > {1'b0, Y_LIM}) ? Y_LIM : y_sum[Y_W:0];
    if (clear) begin
      x0    = '0;
      y0    = '0;
      x_end = X_LIM;
      y_end = Y_LIM;
    end
    zero = (x_end <= {1'b0, x0}) || (y_end <= {1'b0, y0});
  end

endmodule

// File: rtl/fb_rect_writer.sv
// Rectangle-fill / clear engine: accepts a command, then issues one clipped
// pixel write per unstalled cycle in row-major order.
module fb_rect_writer
  import fb_pkg::*;
(
  input  logic             I_clk,
  input  logic             I_rst,
  fb_rect_writer_if.slave  bus
);

  state_t             state;
  logic [X_W-1:0]     col, x_lo;
  logic [Y_W-1:0]     row;
  logic [X_W:0]       x_end;
  logic [Y_W:0]       y_end;
  logic               last_sent;
  logic               busy, done, ie;
  logic [ADDR_W-1:0]  address;
  logic [COL_W-1:0]   colour;

  logic [X_W-1:0]     c_x0;
  logic [Y_W-1:0]     c_y0;
  logic [X_W:0]       c_xe;
  logic [Y_W:0]       c_ye;
  logic               c_zero;

  fb_clip u_clip (
    .clear (bus.I_cmd_clear),
    .x     (bus.I_cmd_x),
    .y     (bus.I_cmd_y),
    .w     (bus.I_cmd_w),
    .h     (bus.I_cmd_h),
    .x0    (c_x0),
    .y0    (c_y0),
    .x_end (c_xe),
    .y_end (c_ye),
    .zero  (c_zero)
  );

  logic               accept, do_emit, row_end, is_last;
  logic [X_W-1:0]     cur_col, cur_lo, nxt_col;
  logic [Y_W-1:0]     cur_row, nxt_row;
  logic [X_W:0]       cur_xe;
  logic [Y_W:0]       cur_ye;

  assign accept = (state == IDLE) && bus.I_cmd_valid && !busy;

  // On the accept cycle the first pixel comes straight from the clip stage.
  always_comb begin
    cur_col = accept ? c_x0 : col;
    cur_row = accept ? c_y0 : row;
    cur_lo  = accept ? c_x0 : x_lo;
    cur_xe  = accept ? c_xe : x_end;
    cur_ye  = accept ? c_ye : y_end;
    row_end = ({1'b0, cur_col} + (X_W+1)'(1)) == cur_xe;
    is_last = row_end && (({1'b0, cur_row} + (Y_W+1)'(1)) == cur_ye);
    nxt_col = row_end ? cur_lo : cur_col + 1'b1;
    nxt_row = row_end ? cur_row + 1'b1 : cur_row;
    do_emit = !bus.I_stall &&
              ((accept && !c_zero) || (state == FILL && !last_sent));
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; later assignments in the block override earlier.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      x_lo      <= '0;
      x_end     <= '0;
      y_end     <= '0;
      last_sent <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ie        <= 1'b0;
      address   <= '0;
      colour    <= '0;
    end else begin
      ie   <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            busy      <= 1'b1;
            colour    <= bus.I_cmd_col;
            x_lo      <= c_x0;
            x_end     <= c_xe;
            y_end     <= c_ye;
            col       <= c_x0;
            row       <= c_y0;
            last_sent <= 1'b0;
            if (c_zero) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= FILL;
            end
          end
        end
        FILL: begin
          if (last_sent) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      if (do_emit) begin
        ie        <= 1'b1;
        address   <= fb_addr(cur_row, cur_col);
        col       <= nxt_col;
        row       <= nxt_row;
        last_sent <= is_last;
      end
    end
  end

  assign bus.O_cmd_ready = !busy;
  assign bus.O_busy      = busy;
  assign bus.O_done      = done;
  assign bus.O_ie        = ie;
  assign bus.O_address   = address;
  assign bus.O_colour    = colour;

endmodule
